mdu_aludec: RTL and testbench
=============================

Name: mdu_aludec

Overview:
- Parametrised successor to the multicycle datapath's ALU decoder.
- Keeps the combinational aluop/funct → alucontrol decode and adds an iterative multiply/divide unit (MDU) with HI/LO registers.
- Sits beside the main controller. The controller pulses start in the R-type execute state, then stalls on stall/busy until done.
- Provides MIPS MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, datapath/operand width in bits (≥4)
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
aluop  in  2  ALU operation class from main decoder
funct  in  6  instruction funct field
start  in  1  issue strobe (R-type execute); sampled only in IDLE
srca  in  WIDTH  rs operand
srcb  in  WIDTH  rt operand
alucontrol  out  3  ALU control, combinational
mdu_op  out  1  combinational: aluop==2'b10 and funct is a MDU code
busy  out  1  MDU iterating (states MUL, DIV, FIX)
done  out  1  one-cycle pulse when HI/LO are updated by MULT*/DIV*
stall  out  1  busy & mdu_op, combinational
hilo_out  out  WIDTH  hi when funct==MFHI, else lo; combinational
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- ALU decode (combinational):
  - aluop 00 → 010 (add); aluop 01 → 110 (sub); aluop 11 → 010.
  - aluop 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - MDU and unknown funct → 010. No X outputs.
- MDU funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- Reset: state IDLE; hi, lo, internal accumulators and counter = 0; busy = 0; done = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, when start & mdu_op:
  - MULT/MULTU → MUL; DIV/DIVU with srcb≠0 → DIV; DIV/DIVU with srcb==0 → DONE.
  - MTHI/MTLO → hi/lo <= srca at this edge; stay in IDLE; no done pulse.
  - MFHI/MFLO → no state change.
- Operand capture on start:
  - Signed ops latch |srca|, |srcb| plus result-sign flags.
  - Unsigned ops latch operands as-is.
  - Counter loaded with WIDTH.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product; exits to FIX after WIDTH cycles.
- DIV: restoring division, one quotient bit per cycle; exits to FIX after WIDTH cycles.
- FIX, one cycle, sign correction:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
- DONE, one cycle:
  - hi/lo written at the transition into DONE.
  - done = 1 while in DONE; returns to IDLE.
- Latency (start sampled at edge 0):
  - done high in cycle WIDTH+2; new hi/lo visible in the same cycle.
  - Divide-by-zero: done in cycle 1 with hi = srca, lo = all ones.
- start while busy or in DONE: ignored, no state change.
- stall blocks a dependent MF*/MT* while busy.
- hilo_out always reflects the current registers; it never forwards an in-flight result.
- Reset mid-operation: abort to IDLE next edge; hi/lo cleared; no done pulse.
- Most negative operand (e.g. 0x80000000 signed): |x| is taken as unsigned magnitude, so results follow two's-complement wrap.

Optional Feature:
MDU_EARLY_OUT_EN
- With the macro: in MUL, exit to FIX as soon as the remaining (already shifted) multiplier bits are all zero, minimum 1 iteration. Latency becomes (index of highest set bit of |srcb|)+1 iterations. DIV is unchanged.
- Without the macro: MUL always runs WIDTH iterations.

Test Plan (WIDTH=32):
- ALU decode: aluop 01 → alucontrol 110; aluop 10 with funct 101010 → 111; aluop 10 with funct 011000 → 010 and mdu_op=1; aluop 10 with funct 111111 → 010.
- MULT srca=0xFFFFFFFD (-3), srcb=7 → done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE. With MDU_EARLY_OUT_EN, MULTU 3×5 → done in cycle 5, lo=15.
- DIVU 100/7 → lo=14, hi=2; DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 5/0 → done in cycle 1, hi=5, lo=0xFFFFFFFF.
- Hazards: start asserted again in cycle 10 of a MULT → ignored, result unchanged. MFHI while busy → stall=1, hilo_out = old hi. MTLO srca=0x1234 in IDLE → lo=0x1234 next cycle, done stays 0.
- Reset asserted in cycle 15 of a DIV → IDLE next edge, busy=0, hi=lo=0, no done pulse; a fresh DIVU 9/3 then completes normally with lo=3, hi=0.

Source files
------------

// File: rtl/mdu_aludec_if.sv
// Controller-side bundle for mdu_aludec: ALU decode inputs/outputs plus the
// multiply/divide issue, status and HI/LO read-back signals.
interface mdu_aludec_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic             start;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [2:0]       alucontrol;
    logic             mdu_op;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hilo_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output aluop, funct, start, srca, srcb,
        input  alucontrol, mdu_op, busy, done, stall, hilo_out, hi, lo
    );

    modport slave (
        input  aluop, funct, start, srca, srcb,
        output alucontrol, mdu_op, busy, done, stall, hilo_out, hi, lo
    );
endinterface

// File: rtl/mdu_aludec.sv
// ALU decoder plus iterative MIPS multiply/divide unit with HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN: multiply stops once remaining multiplier bits are zero.
module mdu_aludec #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic        clk,
    input logic        reset,
    mdu_aludec_if.slave bus
);
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU) ||
               (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or {remainder, quotient}
    logic [2*WIDTH-1:0] opa_q, opa_d;     // shifting multiplicand, or divisor
    logic [WIDTH-1:0]   opb_q, opb_d;     // shifting multiplier, or dividend
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] mul_sum;
    logic               mul_last;
    logic [WIDTH+1:0]   div_trial;
    logic [WIDTH-1:0]   div_shift;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [2*WIDTH-1:0] mul_fix;
    logic               op_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    always_comb begin
        bus.alucontrol = 3'b010;
        case (bus.aluop)
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    F_SUB:   bus.alucontrol = 3'b110;
                    F_AND:   bus.alucontrol = 3'b000;
                    F_OR:    bus.alucontrol = 3'b001;
                    F_SLT:   bus.alucontrol = 3'b111;
                    F_ADD:   bus.alucontrol = 3'b010;
                    default: bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

    assign bus.mdu_op   = (bus.aluop == 2'b10) && is_mdu_funct(bus.funct);
    assign bus.busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.stall    = bus.busy && bus.mdu_op;
    assign bus.hilo_out = (bus.funct == F_MFHI) ? hi_q : lo_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // Operand conditioning: funct bit 0 clear selects the signed variant.
    assign op_signed = ~bus.funct[0];
    assign mag_a     = magnitude(bus.srca, op_signed);
    assign mag_b     = magnitude(bus.srcb, op_signed);

    assign mul_sum = acc_q + (opb_q[0] ? opa_q : '0);
`ifdef MDU_EARLY_OUT_EN
    assign mul_last = (cnt_q == CNT_W'(1)) || (opb_q[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt_q == CNT_W'(1));
`endif

    // Restoring step: borrow in the top bit means the trial subtract failed.
    assign div_shift = {acc_q[2*WIDTH-2:WIDTH], opb_q[WIDTH-1]};
    assign div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH], opb_q[WIDTH-1]} -
                       {2'b00, opa_q[WIDTH-1:0]};

    assign mul_fix  = neg_q ? -acc_q : acc_q;
    assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.mdu_op) begin
                    case (bus.funct)
                        F_MULT, F_MULTU: begin
                            acc_d     = '0;
                            opa_d     = {{WIDTH{1'b0}}, mag_a};
                            opb_d     = mag_b;
                            neg_d     = op_signed && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                            rem_neg_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = CNT_W'(WIDTH);
                            state_d   = S_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            if (bus.srcb == '0) begin
                                hi_d    = bus.srca;
                                lo_d    = '1;
                                state_d = S_DONE;
                            end else begin
                                acc_d     = '0;
                                opa_d     = {{WIDTH{1'b0}}, mag_b};
                                opb_d     = mag_a;
                                neg_d     = op_signed && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                                rem_neg_d = op_signed && bus.srca[WIDTH-1];
                                is_div_d  = 1'b1;
                                cnt_d     = CNT_W'(WIDTH);
                                state_d   = S_DIV;
                            end
                        end
                        F_MTHI:  hi_d = bus.srca;
                        F_MTLO:  lo_d = bus.srca;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (mul_last) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {(div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                opb_d = opb_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = mul_fix[2*WIDTH-1:WIDTH];
                    lo_d = mul_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_aludec.sv
// Directed bench for mdu_aludec (WIDTH=32): ALU decode, MDU results and latency,
// hazards, divide-by-zero and mid-operation reset.
module tb_mdu_aludec;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_aludec_if #(.WIDTH(32)) bus ();

    mdu_aludec #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (edge 0)
    // and the task returns at the falling edge of cycle 1.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.aluop = 2'b10;
        bus.funct = f;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_mdu(input string tag, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_cyc, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input bit hazard,
                           input logic [31:0] old_hi);
        int cyc;
        issue(f, a, b);
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            if (hazard && cyc == 5) begin
                check({tag, "_busy"}, 64'(bus.busy), 64'd1);
                bus.funct = F_MFHI;
                #1;
                check({tag, "_stall"}, 64'(bus.stall), 64'd1);
                check({tag, "_hilo_old"}, 64'(bus.hilo_out), 64'(old_hi));
                bus.funct = f;
            end
            if (hazard && cyc == 10) begin
                bus.srca  = 32'h0000_0055;
                bus.start = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset     = 1'b1;
        bus.aluop = 2'b00;
        bus.funct = 6'b000000;
        bus.start = 1'b0;
        bus.srca  = '0;
        bus.srcb  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        // ALU decode
        bus.aluop = 2'b00; #1; check("dec_add", 64'(bus.alucontrol), 64'b010);
        bus.aluop = 2'b01; #1; check("dec_sub", 64'(bus.alucontrol), 64'b110);
        bus.aluop = 2'b11; #1; check("dec_11", 64'(bus.alucontrol), 64'b010);
        bus.aluop = 2'b10; bus.funct = F_SLT; #1;
        check("dec_slt", 64'(bus.alucontrol), 64'b111);
        check("dec_slt_mdu", 64'(bus.mdu_op), 64'd0);
        bus.funct = 6'b100100; #1; check("dec_and", 64'(bus.alucontrol), 64'b000);
        bus.funct = 6'b100101; #1; check("dec_or", 64'(bus.alucontrol), 64'b001);
        bus.funct = F_MULT; #1;
        check("dec_mult", 64'(bus.alucontrol), 64'b010);
        check("dec_mult_mdu", 64'(bus.mdu_op), 64'd1);
        bus.funct = 6'b111111; #1;
        check("dec_unk", 64'(bus.alucontrol), 64'b010);
        check("dec_unk_mdu", 64'(bus.mdu_op), 64'd0);
        bus.aluop = 2'b01; bus.funct = F_MULT; #1;
        check("dec_mdu_aluop01", 64'(bus.mdu_op), 64'd0);
        @(negedge clk);

        // Moves to HI/LO
        issue(F_MTHI, 32'h0000_ABCD, 32'h0);
        check("mthi_hi", 64'(bus.hi), 64'h0000_ABCD);
        check("mthi_done", 64'(bus.done), 64'd0);
        issue(F_MTLO, 32'h0000_1234, 32'h0);
        check("mtlo_lo", 64'(bus.lo), 64'h0000_1234);
        check("mtlo_done", 64'(bus.done), 64'd0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        bus.funct = F_MFHI; #1; check("mfhi_out", 64'(bus.hilo_out), 64'h0000_ABCD);
        bus.funct = F_MFLO; #1; check("mflo_out", 64'(bus.hilo_out), 64'h0000_1234);
        @(negedge clk);

        // Multiply / divide results and latency
        run_mdu("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 34,
                32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 32'h0000_ABCD);
        run_mdu("multu_big", F_MULTU, 32'hFFFF_FFFF, 32'd2, 34,
                32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32'h0);
`ifdef MDU_EARLY_OUT_EN
        run_mdu("multu_small", F_MULTU, 32'd3, 32'd5, 5, 32'h0, 32'd15, 1'b0, 32'h0);
`else
        run_mdu("multu_small", F_MULTU, 32'd3, 32'd5, 34, 32'h0, 32'd15, 1'b0, 32'h0);
`endif
        run_mdu("mult_minneg", F_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 34,
                32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0);
        run_mdu("divu", F_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 32'h0);
        run_mdu("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 34,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'h0);
        run_mdu("div_zero", F_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b0, 32'h0);

        // Reset in cycle 15 of a divide
        issue(F_DIV, 32'd1000, 32'd3);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rstmid_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_done", 64'(bus.done), 64'd0);
        check("rstmid_hi", 64'(bus.hi), 64'd0);
        check("rstmid_lo", 64'(bus.lo), 64'd0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check("rstmid_no_done", 64'(cyc), 64'd0);
        run_mdu("divu_after_rst", F_DIVU, 32'd9, 32'd3, 34, 32'd0, 32'd3, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
